// File: rtl/io_port_bridge_pkg.sv
// io_port_bridge_pkg: shared CPU port width and default bridge FIFO depth
package io_port_bridge_pkg;
  localparam int PORT_W = 8;
  localparam int DEPTH_DEFAULT = 4;
  typedef logic [PORT_W-1:0] port_t;
endpackage

// File: rtl/io_port_bridge_if.sv
// io_port_bridge_if: host handshakes and CPU port strobes between the bridge and its neighbours
interface io_port_bridge_if;
  import io_port_bridge_pkg::*;
  logic  host_in_valid;
  port_t host_in_data;
  logic  host_in_ready;
  port_t in_port;
  logic  in_rd;
  port_t out_data;
  logic  out_wr;
  logic  host_out_valid;
  port_t host_out_data;
  logic  host_out_ready;
  modport master (
    output host_in_valid, host_in_data, in_rd, out_data, out_wr, host_out_ready,
    input  host_in_ready, in_port, host_out_valid, host_out_data
  );
  modport slave (
    input  host_in_valid, host_in_data, in_rd, out_data, out_wr, host_out_ready,
    output host_in_ready, in_port, host_out_valid, host_out_data
  );
endinterface

// File: rtl/io_port_bridge_sync_fifo.sv
// sync_fifo: circular-buffer FIFO; callers gate push/pop, head reads 0 while empty
module sync_fifo
  import io_port_bridge_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W = PORT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: two FIFOs between a byte-stream host and a CPU's in/out ports
module io_port_bridge
  import io_port_bridge_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  io_port_bridge_if.slave        bus,
  output logic [$clog2(DEPTH):0] in_count,
  output logic [$clog2(DEPTH):0] out_count,
  output logic                   in_underflow,
  output logic                   out_overflow
);
  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;
  assign bus.host_in_ready  = !in_full;
  assign bus.host_out_valid = !out_empty;
  assign in_push  = bus.host_in_valid && !in_full;
  assign in_pop   = bus.in_rd && !in_empty;
  assign out_pop  = !out_empty && bus.host_out_ready;
  // a full output FIFO still takes a write when the host frees a slot this cycle
  assign out_push = bus.out_wr && (!out_full || out_pop);
  sync_fifo #(.DEPTH(DEPTH), .W(PORT_W)) u_in_fifo (
    .clk, .rst, .push(in_push), .pop(in_pop), .din(bus.host_in_data),
    .head(bus.in_port), .count(in_count), .full(in_full), .empty(in_empty)
  );
  sync_fifo #(.DEPTH(DEPTH), .W(PORT_W)) u_out_fifo (
    .clk, .rst, .push(out_push), .pop(out_pop), .din(bus.out_data),
    .head(bus.host_out_data), .count(out_count), .full(out_full), .empty(out_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      in_underflow <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      in_underflow <= in_underflow || (bus.in_rd && in_empty);
      out_overflow <= out_overflow || (bus.out_wr && out_full && !out_pop);
    end
  end
endmodule
